// File: rtl/apb_timer_8bit_if.sv
// APB slave bus bundle for the 8-bit timer: request signals from the master,
// read data and response from the slave.
interface apb_timer_8bit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_8bit.sv
// 8-bit prescaled up/down timer with APB registers TDR/TCR/TSR/TCNT.
// Define TIMER_SLVERR_EN to flag accesses to unmapped or read-only addresses.
module apb_timer_8bit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               pclk,
  input  logic               preset,
  apb_timer_8bit_if.slave    apb,
  output logic               ovf_int,
  output logic               udf_int
);

  localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(3);

  logic [DATA_W-1:0] tdr_q, tdr_d;
  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic              load_q, load_d;
  logic              down_q, down_d;
  logic              en_q, en_d;
  logic [1:0]        cks_q, cks_d;
  logic [1:0]        tsr_q, tsr_d;
  logic [1:0]        tsr_sw;
  logic [3:0]        presc_q, presc_d;
  logic [3:0]        cks_mask;
  logic              wr_en;
  logic              tick;
  logic              ovf_set;
  logic              udf_set;
  logic [DATA_W-1:0] rdata;

  assign wr_en = apb.psel & apb.penable & apb.pwrite;

  always_comb begin
    cks_mask = 4'b0001;
    case (cks_q)
      2'b00: cks_mask = 4'b0001;
      2'b01: cks_mask = 4'b0011;
      2'b10: cks_mask = 4'b0111;
      2'b11: cks_mask = 4'b1111;
      default: cks_mask = 4'b0001;
    endcase
  end

  // Prescaler restarts from zero whenever the timer is stopped or loading,
  // so the first tick after enabling always lands a full period later.
  assign presc_d = (!en_q || load_q) ? 4'd0 : presc_q + 4'd1;
  assign tick    = en_q & ~load_q & ((presc_q & cks_mask) == cks_mask);

  always_comb begin
    tcnt_d  = tcnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (load_q) begin
      tcnt_d = tdr_q;
    end else if (tick) begin
      if (down_q) begin
        udf_set = (tcnt_q == '0);
        tcnt_d  = tcnt_q - DATA_W'(1);
      end else begin
        ovf_set = (tcnt_q == '1);
        tcnt_d  = tcnt_q + DATA_W'(1);
      end
    end
  end

  always_comb begin
    tdr_d  = tdr_q;
    load_d = load_q;
    down_d = down_q;
    en_d   = en_q;
    cks_d  = cks_q;
    tsr_sw = tsr_q;
    if (wr_en) begin
      case (apb.paddr)
        A_TDR: tdr_d = apb.pwdata;
        A_TCR: begin
          load_d = apb.pwdata[7];
          down_d = apb.pwdata[5];
          en_d   = apb.pwdata[4];
          cks_d  = apb.pwdata[1:0];
        end
        A_TSR: tsr_sw = tsr_q & apb.pwdata[1:0];
        default: ;
      endcase
    end
    // A hardware event in the same cycle as a software clear keeps the flag.
    tsr_d = tsr_sw | {udf_set, ovf_set};
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr_q   <= '0;
      tcnt_q  <= '0;
      load_q  <= 1'b0;
      down_q  <= 1'b0;
      en_q    <= 1'b0;
      cks_q   <= 2'b00;
      tsr_q   <= 2'b00;
      presc_q <= 4'd0;
    end else begin
      tdr_q   <= tdr_d;
      tcnt_q  <= tcnt_d;
      load_q  <= load_d;
      down_q  <= down_d;
      en_q    <= en_d;
      cks_q   <= cks_d;
      tsr_q   <= tsr_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (apb.paddr)
      A_TDR:  rdata = tdr_q;
      A_TCR:  rdata = DATA_W'({load_q, 1'b0, down_q, en_q, 2'b00, cks_q});
      A_TSR:  rdata = DATA_W'(tsr_q);
      A_TCNT: rdata = tcnt_q;
      default: rdata = '0;
    endcase
  end

  assign apb.prdata = (apb.psel & ~apb.pwrite) ? rdata : '0;
  assign apb.pready = 1'b1;

`ifdef TIMER_SLVERR_EN
  assign apb.pslverr = apb.psel & apb.penable &
                       ((apb.paddr > A_TCNT) | (apb.pwrite & (apb.paddr == A_TCNT)));
`else
  assign apb.pslverr = 1'b0;
`endif

  assign ovf_int = tsr_q[0];
  assign udf_int = tsr_q[1];

endmodule

// File: tb/tb_apb_timer_8bit.sv
// Directed, table-driven bench for apb_timer_8bit; expected values are
// hand-computed edge by edge from the first enabling write.
module tb_apb_timer_8bit;

  logic pclk;
  logic preset;
  logic ovf_int;
  logic udf_int;

  apb_timer_8bit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_timer_8bit #(.ADDR_W(8), .DATA_W(8)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .apb     (bus.slave),
    .ovf_int (ovf_int),
    .udf_int (udf_int)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_IDLE, OP_INT} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] data;   // write data, expected read data, or expected {udf,ovf}
    int         n;      // idle cycles
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(op_e op, logic [7:0] a, logic [7:0] d, int n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.n = n;
    vecs.push_back(v);
  endfunction

  function automatic logic exp_err(logic [7:0] a, logic wr);
`ifdef TIMER_SLVERR_EN
    return (a > 8'h03) || (wr && a == 8'h03);
`else
    return 1'b0 & (a[0] | wr);
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  // Every bus task starts and ends 1 ns after a rising edge.
  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0;
    bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1 bus.penable = 1'b1;
    #1 check({tag, "_slverr"}, {7'd0, bus.pslverr}, {7'd0, exp_err(a, 1'b1)});
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    $display("%s WR addr=%02h data=%02h", tag, a, d);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] got;
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = a;
    @(posedge pclk); #1 bus.penable = 1'b1;
    #1 got = bus.prdata;
    check({tag, "_prdata"}, got, exp);
    check({tag, "_slverr"}, {7'd0, bus.pslverr}, {7'd0, exp_err(a, 1'b0)});
    check({tag, "_pready"}, {7'd0, bus.pready}, 8'h01);
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    $display("%s RD addr=%02h data=%02h", tag, a, got);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 8'h00; bus.pwdata = 8'h00;
    preset = 1'b1;

    // reset state
    add(OP_RD, 8'h00, 8'h00, 0); add(OP_RD, 8'h01, 8'h00, 0);
    add(OP_RD, 8'h02, 8'h00, 0); add(OP_RD, 8'h03, 8'h00, 0);
    add(OP_RD, 8'h05, 8'h00, 0); add(OP_INT, 8'h00, 8'h00, 0);
    // /2 down from 0xFF: underflow on edge 512 after enable (E0)
    add(OP_WR, 8'h00, 8'hFF, 0); add(OP_WR, 8'h01, 8'h80, 0);
    add(OP_WR, 8'h01, 8'h30, 0);
    add(OP_IDLE, 0, 0, 499);     add(OP_RD, 8'h02, 8'h00, 0);   // state @E500
    add(OP_IDLE, 0, 0, 10);      add(OP_INT, 8'h00, 8'h00, 0);  // @E511
    add(OP_RD, 8'h03, 8'hFF, 0);                                 // @E512
    add(OP_INT, 8'h00, 8'h02, 0);                                // @E513
    add(OP_RD, 8'h02, 8'h02, 0);  add(OP_RD, 8'h01, 8'h30, 0);
    add(OP_WR, 8'h01, 8'h00, 0);  add(OP_RD, 8'h03, 8'hFC, 0);
    add(OP_WR, 8'h02, 8'h00, 0);  add(OP_RD, 8'h02, 8'h00, 0);
    add(OP_INT, 8'h00, 8'h00, 0);
    // EN=0 holds TCNT; re-enable restarts prescaler phase (F0)
    add(OP_WR, 8'h01, 8'h20, 0);  add(OP_IDLE, 0, 0, 20);
    add(OP_RD, 8'h03, 8'hFC, 0);  add(OP_WR, 8'h01, 8'h30, 0);
    add(OP_RD, 8'h03, 8'hFC, 0);  add(OP_RD, 8'h03, 8'hFB, 0);
    add(OP_WR, 8'h01, 8'h00, 0);  add(OP_RD, 8'h03, 8'hF9, 0);
    // load, TDR write without load, reserved bits, unmapped/RO writes
    add(OP_WR, 8'h00, 8'h5A, 0);  add(OP_WR, 8'h01, 8'h80, 0);
    add(OP_WR, 8'h01, 8'h00, 0);  add(OP_RD, 8'h03, 8'h5A, 0);
    add(OP_WR, 8'h00, 8'h33, 0);  add(OP_RD, 8'h03, 8'h5A, 0);
    add(OP_RD, 8'h00, 8'h33, 0);  add(OP_WR, 8'h01, 8'hFF, 0);
    add(OP_RD, 8'h03, 8'h33, 0);  add(OP_RD, 8'h01, 8'hB3, 0);
    add(OP_WR, 8'h01, 8'h00, 0);  add(OP_WR, 8'h07, 8'hAA, 0);
    add(OP_RD, 8'h07, 8'h00, 0);  add(OP_WR, 8'h03, 8'h77, 0);
    add(OP_RD, 8'h03, 8'h33, 0);
    // /4 up from 0xFE: overflow on edge 8 (G0)
    add(OP_WR, 8'h00, 8'hFE, 0);  add(OP_WR, 8'h01, 8'h80, 0);
    add(OP_WR, 8'h01, 8'h11, 0);
    add(OP_IDLE, 0, 0, 7);        add(OP_INT, 8'h00, 8'h00, 0);
    add(OP_IDLE, 0, 0, 1);        add(OP_INT, 8'h00, 8'h01, 0);
    add(OP_RD, 8'h03, 8'h00, 0);  add(OP_RD, 8'h02, 8'h01, 0);
    // /4 down from 0x00: both flags, write-1 holds (H0)
    add(OP_WR, 8'h00, 8'h00, 0);  add(OP_WR, 8'h01, 8'h80, 0);
    add(OP_WR, 8'h01, 8'h31, 0);  add(OP_IDLE, 0, 0, 4);
    add(OP_INT, 8'h00, 8'h03, 0); add(OP_WR, 8'h02, 8'h03, 0);
    add(OP_RD, 8'h02, 8'h03, 0);
    // clear committed on the underflow edge: set wins (J0, clear at J4)
    add(OP_WR, 8'h01, 8'h80, 0);  add(OP_WR, 8'h01, 8'h31, 0);
    add(OP_IDLE, 0, 0, 2);        add(OP_WR, 8'h02, 8'h00, 0);
    add(OP_RD, 8'h02, 8'h02, 0);  add(OP_INT, 8'h00, 8'h02, 0);
    add(OP_WR, 8'h02, 8'h00, 0);  add(OP_RD, 8'h02, 8'h00, 0);
    add(OP_WR, 8'h01, 8'h00, 0);
    // /8 up from 0x10 (K0): ticks on edges 8 and 16
    add(OP_WR, 8'h00, 8'h10, 0);  add(OP_WR, 8'h01, 8'h80, 0);
    add(OP_WR, 8'h01, 8'h12, 0);  add(OP_IDLE, 0, 0, 7);
    add(OP_RD, 8'h03, 8'h11, 0);  add(OP_IDLE, 0, 0, 6);
    add(OP_RD, 8'h03, 8'h12, 0);
    // /16 up from 0x10 (M0): first tick on edge 16
    add(OP_WR, 8'h01, 8'h80, 0);  add(OP_WR, 8'h01, 8'h13, 0);
    add(OP_IDLE, 0, 0, 14);       add(OP_RD, 8'h03, 8'h10, 0);
    add(OP_RD, 8'h03, 8'h11, 0);

    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      case (vecs[i].op)
        OP_WR:   do_write(tag, vecs[i].addr, vecs[i].data);
        OP_RD:   do_read(tag, vecs[i].addr, vecs[i].data);
        OP_IDLE: idle(vecs[i].n);
        OP_INT: begin
          check({tag, "_int"}, {6'd0, udf_int, ovf_int}, vecs[i].data);
          $display("%s INT udf=%0b ovf=%0b", tag, udf_int, ovf_int);
        end
        default: ;
      endcase
    end

    // Asynchronous reset asserted mid-cycle while the timer is running.
    do_write("ar", 8'h01, 8'h30);
    idle(3);
    #2 preset = 1'b1;
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = 8'h01;
    #1 check("async_rst_tcr", bus.prdata, 8'h00);
    bus.paddr = 8'h03;
    #1 check("async_rst_tcnt", bus.prdata, 8'h00);
    check("async_rst_int", {6'd0, udf_int, ovf_int}, 8'h00);
    $display("ar ASYNC_RESET tcr/tcnt read while preset high");
    bus.psel = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    do_read("ar_post", 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
